// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta multi-cycle control path:
// sequencer states, PC-select codes, ALU functions and control-word field positions.
package beta_pkg;

    typedef enum logic [1:0] {
        ST_RST,
        ST_FETCH,
        ST_EXEC,
        ST_MEM
    } state_t;

    localparam logic [2:0] PCSEL_INC    = 3'd0;
    localparam logic [2:0] PCSEL_BRANCH = 3'd1;
    localparam logic [2:0] PCSEL_JMP    = 3'd2;
    localparam logic [2:0] PCSEL_ILLOP  = 3'd3;
    localparam logic [2:0] PCSEL_XADR   = 3'd4;
    localparam logic [2:0] PCSEL_RESET  = 3'd5;

    localparam logic [3:0] ALUFN_ADD   = 4'h0;
    localparam logic [3:0] ALUFN_SUB   = 4'h1;
    localparam logic [3:0] ALUFN_MUL   = 4'h2;
    localparam logic [3:0] ALUFN_CMPEQ = 4'h5;
    localparam logic [3:0] ALUFN_CMPLT = 4'h6;
    localparam logic [3:0] ALUFN_CMPLE = 4'h7;
    localparam logic [3:0] ALUFN_AND   = 4'h8;
    localparam logic [3:0] ALUFN_OR    = 4'h9;
    localparam logic [3:0] ALUFN_XOR   = 4'hA;
    localparam logic [3:0] ALUFN_XNOR  = 4'hB;
    localparam logic [3:0] ALUFN_SHL   = 4'hC;
    localparam logic [3:0] ALUFN_SHR   = 4'hD;
    localparam logic [3:0] ALUFN_SRA   = 4'hE;
    localparam logic [3:0] ALUFN_A     = 4'hF;

    // ctl_word layout: {wdsel[1:0], pcsel[1:0], mwr, moe, werf, alufn[3:0]}
    localparam int unsigned CTL_WDSEL_HI = 10;
    localparam int unsigned CTL_WDSEL_LO = 9;
    localparam int unsigned CTL_PCSEL_HI = 8;
    localparam int unsigned CTL_PCSEL_LO = 7;
    localparam int unsigned CTL_MWR      = 6;
    localparam int unsigned CTL_MOE      = 5;
    localparam int unsigned CTL_WERF     = 4;
    localparam int unsigned CTL_ALUFN_HI = 3;
    localparam int unsigned CTL_ALUFN_LO = 0;

    localparam logic [1:0] WDSEL_PC4 = 2'd0;
    localparam logic [4:0] XP_REG    = 5'd30;

endpackage

// File: rtl/beta_sequencer.sv
// Multi-cycle Beta sequencer: fetch/execute/memory phasing with ready stalls,
// illegal-opcode and interrupt traps, write-enable gating and retired-instruction count.
module beta_sequencer
    import beta_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          ctl_word,
    input  logic                 irq,
    input  logic                 supervisor,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 dmem_oe,
    output logic                 rf_we,
    output logic                 wasel,
    output logic [1:0]           wdsel,
    output logic [3:0]           alufn,
    output logic [2:0]           pcsel,
    output logic                 pc_load,
    output logic                 irq_ack,
    output logic [INSTRET_W-1:0] instret
);

    state_t     state;
    state_t     nextState;
    logic       retire;

    logic [1:0] ctlWdsel;
    logic [1:0] ctlPcsel;
    logic       ctlMwr;
    logic       ctlMoe;
    logic       ctlWerf;
    logic [3:0] ctlAlufn;
    logic       irqTake;
    logic       illTake;

    assign ctlWdsel = ctl_word[CTL_WDSEL_HI:CTL_WDSEL_LO];
    assign ctlPcsel = ctl_word[CTL_PCSEL_HI:CTL_PCSEL_LO];
    assign ctlMwr   = ctl_word[CTL_MWR];
    assign ctlMoe   = ctl_word[CTL_MOE];
    assign ctlWerf  = ctl_word[CTL_WERF];
    assign ctlAlufn = ctl_word[CTL_ALUFN_HI:CTL_ALUFN_LO];
    assign irqTake  = irq && !supervisor;
    assign illTake  = (ctlPcsel == 2'b11);

    // Outputs are Mealy on the ready handshakes so a zero-wait memory commits in its request cycle.
    always_comb begin
        nextState = state;
        retire    = 1'b0;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_oe   = 1'b0;
        rf_we     = 1'b0;
        wasel     = 1'b0;
        wdsel     = ctlWdsel;
        alufn     = ctlAlufn;
        pcsel     = PCSEL_INC;
        pc_load   = 1'b0;
        irq_ack   = 1'b0;

        case (state)
            ST_RST: begin
                pcsel     = PCSEL_RESET;
                pc_load   = 1'b1;
                nextState = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load   = 1'b1;
                    nextState = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (irqTake || illTake) begin
                    rf_we     = 1'b1;
                    wasel     = 1'b1;
                    wdsel     = WDSEL_PC4;
                    pcsel     = irqTake ? PCSEL_XADR : PCSEL_ILLOP;
                    pc_load   = 1'b1;
                    irq_ack   = irqTake;
                    nextState = ST_FETCH;
                end else if (ctlMwr || ctlMoe) begin
                    nextState = ST_MEM;
                end else begin
                    rf_we     = ctlWerf;
                    pcsel     = {1'b0, ctlPcsel};
                    pc_load   = 1'b1;
                    retire    = 1'b1;
                    nextState = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctlMwr;
                dmem_oe  = ctlMoe;
                if (dmem_ready) begin
                    rf_we     = ctlWerf;
                    pcsel     = PCSEL_INC;
                    pc_load   = 1'b1;
                    retire    = 1'b1;
                    nextState = ST_FETCH;
                end
            end
            default: nextState = ST_RST;
        endcase

        if (reset) begin
            retire   = 1'b0;
            imem_req = 1'b0;
            ir_load  = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            dmem_oe  = 1'b0;
            rf_we    = 1'b0;
            wasel    = 1'b0;
            wdsel    = '0;
            alufn    = '0;
            pcsel    = '0;
            pc_load  = 1'b0;
            irq_ack  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RST;
            instret <= '0;
        end else begin
            state <= nextState;
            if (retire) begin
                instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_beta_sequencer.sv
// Directed self-checking bench for beta_sequencer: one task per scenario,
// inputs driven 1 time unit after the rising edge and outputs checked 1 unit later.
module tb_beta_sequencer;

    logic        clk;
    logic        reset;
    logic [10:0] ctl_word;
    logic        irq;
    logic        supervisor;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_oe;
    logic        rf_we;
    logic        wasel;
    logic [1:0]  wdsel;
    logic [3:0]  alufn;
    logic [2:0]  pcsel;
    logic        pc_load;
    logic        irq_ack;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    logic [17:0] obs;
    assign obs = {imem_req, ir_load, dmem_req, dmem_we, dmem_oe, rf_we, wasel,
                  wdsel, alufn, pcsel, pc_load, irq_ack};

    beta_sequencer #(.INSTRET_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctl_word   (ctl_word),
        .irq        (irq),
        .supervisor (supervisor),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_oe    (dmem_oe),
        .rf_we      (rf_we),
        .wasel      (wasel),
        .wdsel      (wdsel),
        .alufn      (alufn),
        .pcsel      (pcsel),
        .pc_load    (pc_load),
        .irq_ack    (irq_ack),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs expected output fields in the same order as obs.
    function automatic logic [17:0] pk(input logic iq, input logic il, input logic dq,
                                       input logic dw, input logic doe, input logic rw,
                                       input logic ws, input logic [1:0] wd,
                                       input logic [3:0] af, input logic [2:0] ps,
                                       input logic pl, input logic ia);
        return {iq, il, dq, dw, doe, rw, ws, wd, af, ps, pl, ia};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; ctl_word = 11'b00_00_0_0_1_0000; irq = 1'b0; supervisor = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if (obs !== 18'h0) begin
            errors++; $display("FAIL reset_outputs got %h expected %h", obs, 18'h0);
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++; $display("FAIL reset_instret got %0d expected 0", instret);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,0,0,2'd0,4'h0,3'd5,1,0)) begin
            errors++; $display("FAIL rst_state got %h expected %h", obs, pk(0,0,0,0,0,0,0,2'd0,4'h0,3'd5,1,0));
        end
    endtask

    task automatic test_alu;
        tick(); #1;
        checks++;
        if (obs !== pk(1,1,0,0,0,0,0,2'd0,4'h0,3'd0,0,0)) begin
            errors++; $display("FAIL alu_fetch got %h expected %h", obs, pk(1,1,0,0,0,0,0,2'd0,4'h0,3'd0,0,0));
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,1,0,2'd0,4'h0,3'd0,1,0)) begin
            errors++; $display("FAIL alu_exec got %h expected %h", obs, pk(0,0,0,0,0,1,0,2'd0,4'h0,3'd0,1,0));
        end
        tick(); #1;
        checks++;
        if (instret !== 32'd1) begin
            errors++; $display("FAIL alu_instret got %0d expected 1", instret);
        end
    endtask

    task automatic test_load;
        ctl_word = 11'b10_00_0_1_1_0000; imem_ready = 1'b1; dmem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== pk(1,1,0,0,0,0,0,2'd2,4'h0,3'd0,0,0)) begin
            errors++; $display("FAIL ld_fetch got %h expected %h", obs, pk(1,1,0,0,0,0,0,2'd2,4'h0,3'd0,0,0));
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,0,0,2'd2,4'h0,3'd0,0,0)) begin
            errors++; $display("FAIL ld_exec got %h expected %h", obs, pk(0,0,0,0,0,0,0,2'd2,4'h0,3'd0,0,0));
        end
        for (int i = 0; i < 3; i++) begin
            tick(); dmem_ready = 1'b0; #1;
            checks++;
            if (obs !== pk(0,0,1,0,1,0,0,2'd2,4'h0,3'd0,0,0)) begin
                errors++; $display("FAIL ld_wait%0d got %h expected %h", i, obs, pk(0,0,1,0,1,0,0,2'd2,4'h0,3'd0,0,0));
            end
        end
        checks++;
        if (instret !== 32'd1) begin
            errors++; $display("FAIL ld_instret_hold got %0d expected 1", instret);
        end
        tick(); dmem_ready = 1'b1; #1;
        checks++;
        if (obs !== pk(0,0,1,0,1,1,0,2'd2,4'h0,3'd0,1,0)) begin
            errors++; $display("FAIL ld_done got %h expected %h", obs, pk(0,0,1,0,1,1,0,2'd2,4'h0,3'd0,1,0));
        end
        tick(); #1;
        checks++;
        if (instret !== 32'd2) begin
            errors++; $display("FAIL ld_instret got %0d expected 2", instret);
        end
    endtask

    task automatic test_store;
        ctl_word = 11'b00_00_1_0_0_0001; imem_ready = 1'b1; dmem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== pk(1,1,0,0,0,0,0,2'd0,4'h1,3'd0,0,0)) begin
            errors++; $display("FAIL st_fetch got %h expected %h", obs, pk(1,1,0,0,0,0,0,2'd0,4'h1,3'd0,0,0));
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,0,0,2'd0,4'h1,3'd0,0,0)) begin
            errors++; $display("FAIL st_exec got %h expected %h", obs, pk(0,0,0,0,0,0,0,2'd0,4'h1,3'd0,0,0));
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,1,1,0,0,0,2'd0,4'h1,3'd0,0,0)) begin
            errors++; $display("FAIL st_wait got %h expected %h", obs, pk(0,0,1,1,0,0,0,2'd0,4'h1,3'd0,0,0));
        end
        tick(); dmem_ready = 1'b1; #1;
        checks++;
        if (obs !== pk(0,0,1,1,0,0,0,2'd0,4'h1,3'd0,1,0)) begin
            errors++; $display("FAIL st_done got %h expected %h", obs, pk(0,0,1,1,0,0,0,2'd0,4'h1,3'd0,1,0));
        end
        tick(); #1;
        checks++;
        if (instret !== 32'd3) begin
            errors++; $display("FAIL st_instret got %0d expected 3", instret);
        end
    endtask

    task automatic test_traps;
        ctl_word = 11'b01_11_0_0_1_0001; irq = 1'b1; supervisor = 1'b0; imem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== pk(1,1,0,0,0,0,0,2'd1,4'h1,3'd0,0,0)) begin
            errors++; $display("FAIL trap_fetch got %h expected %h", obs, pk(1,1,0,0,0,0,0,2'd1,4'h1,3'd0,0,0));
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,1,1,2'd0,4'h1,3'd4,1,1)) begin
            errors++; $display("FAIL trap_irq got %h expected %h", obs, pk(0,0,0,0,0,1,1,2'd0,4'h1,3'd4,1,1));
        end
        tick(); supervisor = 1'b1; #1;
        checks++;
        if (instret !== 32'd3) begin
            errors++; $display("FAIL trap_irq_instret got %0d expected 3", instret);
        end
        checks++;
        if (obs !== pk(1,1,0,0,0,0,0,2'd1,4'h1,3'd0,0,0)) begin
            errors++; $display("FAIL trap_fetch2 got %h expected %h", obs, pk(1,1,0,0,0,0,0,2'd1,4'h1,3'd0,0,0));
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,1,1,2'd0,4'h1,3'd3,1,0)) begin
            errors++; $display("FAIL trap_illop got %h expected %h", obs, pk(0,0,0,0,0,1,1,2'd0,4'h1,3'd3,1,0));
        end
        tick(); irq = 1'b0; supervisor = 1'b0; #1;
        checks++;
        if (instret !== 32'd3) begin
            errors++; $display("FAIL trap_ill_instret got %0d expected 3", instret);
        end
    endtask

    task automatic test_branch;
        ctl_word = 11'b00_00_0_0_1_0000; imem_ready = 1'b0; dmem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== pk(1,0,0,0,0,0,0,2'd0,4'h0,3'd0,0,0)) begin
            errors++; $display("FAIL br_fetch_stall got %h expected %h", obs, pk(1,0,0,0,0,0,0,2'd0,4'h0,3'd0,0,0));
        end
        tick(); imem_ready = 1'b1; #1;
        checks++;
        if (obs !== pk(1,1,0,0,0,0,0,2'd0,4'h0,3'd0,0,0)) begin
            errors++; $display("FAIL br_fetch got %h expected %h", obs, pk(1,1,0,0,0,0,0,2'd0,4'h0,3'd0,0,0));
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,1,0,2'd0,4'h0,3'd0,1,0)) begin
            errors++; $display("FAIL br_not_taken got %h expected %h", obs, pk(0,0,0,0,0,1,0,2'd0,4'h0,3'd0,1,0));
        end
        tick(); ctl_word = 11'b00_01_0_0_1_0000; #1;
        checks++;
        if (instret !== 32'd4) begin
            errors++; $display("FAIL br_instret1 got %0d expected 4", instret);
        end
        tick(); #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,1,0,2'd0,4'h0,3'd1,1,0)) begin
            errors++; $display("FAIL br_taken got %h expected %h", obs, pk(0,0,0,0,0,1,0,2'd0,4'h0,3'd1,1,0));
        end
        tick(); #1;
        checks++;
        if (instret !== 32'd5) begin
            errors++; $display("FAIL br_instret2 got %0d expected 5", instret);
        end
    endtask

    task automatic test_reset_mid_mem;
        ctl_word = 11'b10_00_0_1_1_0000; imem_ready = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); #1;
        checks++;
        if (obs !== pk(0,0,1,0,1,0,0,2'd2,4'h0,3'd0,0,0)) begin
            errors++; $display("FAIL rmem_wait got %h expected %h", obs, pk(0,0,1,0,1,0,0,2'd2,4'h0,3'd0,0,0));
        end
        tick(); reset = 1'b1; #1;
        checks++;
        if (obs !== 18'h0) begin
            errors++; $display("FAIL rmem_gated got %h expected %h", obs, 18'h0);
        end
        checks++;
        if (instret !== 32'd5) begin
            errors++; $display("FAIL rmem_instret_pre got %0d expected 5", instret);
        end
        tick(); reset = 1'b0; #1;
        checks++;
        if (obs !== pk(0,0,0,0,0,0,0,2'd2,4'h0,3'd5,1,0)) begin
            errors++; $display("FAIL rmem_rst got %h expected %h", obs, pk(0,0,0,0,0,0,0,2'd2,4'h0,3'd5,1,0));
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++; $display("FAIL rmem_instret got %0d expected 0", instret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_traps();
        test_branch();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beta_sequencer.md
Name: beta_sequencer

Overview:
- Multi-cycle sequencer for the Beta datapath.
- Takes the 11-bit control word from the opcode decoder, which is combinational on the IR opcode and z.
- Splits each instruction into fetch, execute and memory phases, stalling on ready handshakes from instruction and data memory.
- Handles illegal-opcode and interrupt traps, gates the register-file and PC write enables, and counts retired instructions.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ctl_word  in  11  decoder output {wdsel[1:0], pcsel[1:0], mwr, moe, werf, alufn[3:0]}.
- irq  in  1  level interrupt request.
- supervisor  in  1  PC[31]; interrupts are masked while this is 1.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  latch instruction register.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write strobe, valid with dmem_req.
- dmem_oe  out  1  data read enable, valid with dmem_req.
- rf_we  out  1  register-file write enable.
- wasel  out  1  1 = write address forced to XP (R30).
- wdsel  out  2  write-data select, passed through from ctl_word except during traps.
- alufn  out  4  ALU function, passed through from ctl_word.
- pcsel  out  3  0 PC+4, 1 branch, 2 JMP, 3 ILLOP, 4 XADR, 5 RESET.
- pc_load  out  1  commit next PC.
- irq_ack  out  1  one-cycle pulse when an interrupt trap is taken.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- States: RST, FETCH, EXEC, MEM. Reset forces RST. While reset is high, every output except instret is 0, combinationally gated. instret resets to 0.
- RST: pcsel=5, pc_load=1 for one cycle, then go to FETCH.
- FETCH: imem_req=1. When imem_ready=1: ir_load=1 and go to EXEC. Otherwise hold; there is no timeout.
- EXEC: ctl_word is sampled here (the IR is stable, z is live). Priority, highest first:
  1. Interrupt trap (irq && !supervisor): rf_we=1, wasel=1, wdsel=0 (XP<=PC+4), pcsel=4, pc_load=1, irq_ack=1; go to FETCH. The instruction is not executed and instret is unchanged.
  2. Illegal trap (ctl_word pcsel==2'b11): same as the interrupt trap but pcsel=3 and irq_ack=0.
  3. Memory op (mwr|moe): go to MEM with no commit this cycle.
  4. Otherwise commit: rf_we=werf, wasel=0, wdsel/alufn from ctl_word, pcsel={1'b0, ctl pcsel}, pc_load=1, instret+=1; go to FETCH.
- MEM: dmem_req=1, dmem_we=mwr, dmem_oe=moe, alufn from ctl_word (address calculation).
  - On dmem_ready: rf_we=werf, wdsel from ctl_word, pcsel=0, pc_load=1, instret+=1; go to FETCH.
  - Otherwise hold with all commit strobes 0.
  - irq is ignored in MEM; it is taken at the next EXEC.
- Latency with zero-wait memories (ready in the request cycle): ALU/branch/JMP take 2 cycles; LD/ST take 3; traps take 2.
- rf_we, pc_load and ir_load are each asserted for at most one cycle per instruction.
- instret wraps modulo 2^INSTRET_W.
- Reset mid-FETCH or mid-MEM: requests drop in the same cycle (gating), there is no commit, and the next state is RST.
- imem_ready/dmem_ready asserted outside their request state are ignored.

Decomposition:
- beta_pkg holds:
  - state enum (RST, FETCH, EXEC, MEM);
  - pcsel encodings (PCSEL_INC..PCSEL_RESET);
  - ALUFN constants;
  - ctl_word field index constants;
  - XP register index 30.
- No sub-module: a single FSM plus the instret counter. The opcode decoder stays a separate instance in the datapath top.

Test Plan:
- Reset then ALU op (ctl_word={00,00,0,0,1,ADD}), imem_ready and dmem_ready tied high:
  - cycle 1: pcsel=5, pc_load=1;
  - FETCH: ir_load=1;
  - EXEC: rf_we=1, pcsel=0, pc_load=1;
  - instret=1 after 3 cycles.
- LD (moe=1, werf=1, wdsel=2) with dmem_ready delayed 3 cycles: dmem_req high for 4 cycles with rf_we=0; rf_we and pc_load pulse only in the ready cycle; instret increments once.
- ST (mwr=1, werf=0): dmem_we=1 throughout MEM, rf_we stays 0 on completion, pc_load=1.
- Illegal opcode (ctl_word pcsel=2'b11) with irq=1 and supervisor=0: interrupt wins, pcsel=4, irq_ack=1, wasel=1, wdsel=0, instret unchanged. Repeat with supervisor=1: pcsel=3, irq_ack=0.
- BEQ with z toggling (ctl pcsel 00/01): pcsel output follows ctl in EXEC, i.e. 0 when not taken, 1 when taken.
- Assert reset during MEM with dmem_ready=0: dmem_req=0 in the same cycle, no rf_we, next cycle is RST (pcsel=5), instret=0.
